// File: rtl/wb_bringup_initiator.sv
// rtl/wb_bringup_initiator.sv - Wishbone classic single-access bring-up initiator
//
// Takes one command at a time, runs one classic Wishbone cycle on the
// wrapper's wbs_* port, and returns read data / timeout status.
//
// Ports:
//   clock, reset           sole clock; synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready decoded, IDLE && !reset)
//   cmd_we/adr/dat/sel     command fields, latched on acceptance
//   rsp_valid/rsp_ready    response handshake
//   rsp_dat, rsp_timeout   read data (0 for writes/timeouts), abort flag
//   wbm_cyc_o..wbm_dat_o   registered Wishbone initiator outputs
//   wbm_ack_i, wbm_dat_i   Wishbone slave ack and read data
//   stat_txn_count         (WB_BRINGUP_INITIATOR_STATS_EN) completed cycles
//   stat_timeout_count     (WB_BRINGUP_INITIATOR_STATS_EN) aborted cycles
//
// Optional feature macro: WB_BRINGUP_INITIATOR_STATS_EN

module wb_bringup_initiator #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int ADR_WIDTH      = 32,
   parameter int DAT_WIDTH      = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_we,
   input  logic [ADR_WIDTH-1:0]   cmd_adr,
   input  logic [DAT_WIDTH-1:0]   cmd_dat,
   input  logic [DAT_WIDTH/8-1:0] cmd_sel,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DAT_WIDTH-1:0]   rsp_dat,
   output logic                   rsp_timeout,
   output logic                   wbm_cyc_o,
   output logic                   wbm_stb_o,
   output logic                   wbm_we_o,
   output logic [DAT_WIDTH/8-1:0] wbm_sel_o,
   output logic [ADR_WIDTH-1:0]   wbm_adr_o,
   output logic [DAT_WIDTH-1:0]   wbm_dat_o,
   input  logic                   wbm_ack_i,
   input  logic [DAT_WIDTH-1:0]   wbm_dat_i
`ifdef WB_BRINGUP_INITIATOR_STATS_EN
   ,
   output logic [15:0]            stat_txn_count,
   output logic [15:0]            stat_timeout_count
`endif
);

   // A zero timeout still needs a 1-bit timer so the declarations stay legal;
   // the comparison below is disabled in that case.
   localparam int TMR_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TERM_INT  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [TMR_WIDTH-1:0] TMR_TERM = TMR_WIDTH'(TERM_INT);
   localparam logic [TMR_WIDTH-1:0] TMR_MAX  = '1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]           state;
   logic [TMR_WIDTH-1:0] timer;
   logic                 timeout_hit;

   assign cmd_ready   = (state == ST_IDLE) && !reset;
   // Timer counts completed no-ack stb cycles; the terminal value is reached on
   // the TIMEOUT_CYCLES-th stb-high cycle.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TMR_TERM);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         timer       <= '0;
         rsp_valid   <= 1'b0;
         rsp_dat     <= '0;
         rsp_timeout <= 1'b0;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= '0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  wbm_we_o  <= cmd_we;
                  wbm_adr_o <= cmd_adr;
                  wbm_dat_o <= cmd_dat;
                  wbm_sel_o <= cmd_sel;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  timer     <= '0;
                  state     <= ST_BUS;
               end
            end
            ST_BUS: begin
               // Ack takes priority over a timeout landing on the same cycle.
               if (wbm_ack_i) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  wbm_we_o    <= 1'b0;
                  rsp_dat     <= wbm_we_o ? '0 : wbm_dat_i;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= ST_RESP;
               end else if (timeout_hit) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  wbm_we_o    <= 1'b0;
                  rsp_dat     <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= ST_RESP;
               end else if (timer != TMR_MAX) begin
                  timer <= timer + TMR_WIDTH'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef WB_BRINGUP_INITIATOR_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_txn_count     <= '0;
         stat_timeout_count <= '0;
      end else if (state == ST_BUS) begin
         if (wbm_ack_i || timeout_hit) begin
            if (stat_txn_count != 16'hFFFF)
               stat_txn_count <= stat_txn_count + 16'd1;
         end
         if (!wbm_ack_i && timeout_hit) begin
            if (stat_timeout_count != 16'hFFFF)
               stat_timeout_count <= stat_timeout_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/wb_bringup_initiator.md
Name: wb_bringup_initiator

Overview:
- Wishbone classic single-access initiator that drives the user project wrapper's `wbs_*` slave port during bring-up.
- Accepts one command at a time (address, data, write-enable, byte-select) over a valid/ready handshake.
- Runs a single classic Wishbone cycle, waits for ack or a timeout, then returns read data and status over a second valid/ready handshake.
- Instantiated in bring-up benches and, later, in firmware-payload harnesses alongside `user_project_wrapper`.

Parameters:
- TIMEOUT_CYCLES, 256, max cycles stb is held without ack before abort; 0 = no timeout (wait forever).
- ADR_WIDTH, 32, address width.
- DAT_WIDTH, 32, data width; must be a multiple of 8.

Ports:
- clock  in  1  sole clock, shared with wrapper `wb_clk_i`
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&&ready at posedge
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  ADR_WIDTH  byte address
- cmd_dat  in  DAT_WIDTH  write data
- cmd_sel  in  DAT_WIDTH/8  byte selects
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&&ready at posedge
- rsp_dat  out  DAT_WIDTH  read data; 0 for writes and timeouts
- rsp_timeout  out  1  1 = cycle aborted, no ack
- wbm_cyc_o  out  1  to `wbs_cyc_i`
- wbm_stb_o  out  1  to `wbs_stb_i`
- wbm_we_o  out  1  to `wbs_we_i`
- wbm_sel_o  out  DAT_WIDTH/8  to `wbs_sel_i`
- wbm_adr_o  out  ADR_WIDTH  to `wbs_adr_i`
- wbm_dat_o  out  DAT_WIDTH  to `wbs_dat_i`
- wbm_ack_i  in  1  from `wbs_ack_o`
- wbm_dat_i  in  DAT_WIDTH  from `wbs_dat_o`

Behaviour:
Reset and timing rules:
- Reset is synchronous and active-high. Clock and reset ports are named `clock` and `reset`.
- Reset values: state=IDLE, cmd_ready=0 while reset is high, rsp_valid=0, rsp_timeout=0, rsp_dat=0, all wbm_* outputs=0, timer=0.
- All outputs are registered except cmd_ready, which is decoded (state==IDLE && !reset).

State IDLE:
- cmd_ready=1.
- On cmd_valid: latch we/adr/dat/sel into wbm_* outputs, set wbm_cyc_o=wbm_stb_o=1, clear timer, go to BUS.
- First stb-high cycle is the cycle after acceptance.

State BUS:
- cyc/stb/adr/we/sel/dat are held stable.
- Timer increments each cycle with no ack.
- On wbm_ack_i:
  - cyc/stb/we cleared at that edge.
  - rsp_dat = wbm_dat_i for a read, 0 for a write.
  - rsp_timeout=0, rsp_valid=1, go to RESP.
- If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 with no ack:
  - cyc/stb cleared, rsp_dat=0, rsp_timeout=1, rsp_valid=1, go to RESP.
- Ack and timeout terminal count in the same cycle: ack wins, rsp_timeout=0.
- wbm_adr_o/dat_o/sel_o keep their last value after the cycle ends. Only cyc/stb/we return to 0.

State RESP:
- rsp_valid, rsp_dat and rsp_timeout are held until rsp_ready.
- On rsp_ready: rsp_valid=0, go to IDLE.
- No new command is accepted in this state. Minimum period with a zero-wait (registered-ack) slave is 4 cycles per transaction.

Other boundary conditions:
- wbm_ack_i outside BUS is ignored and does not change any output.
- Reset asserted mid-BUS or mid-RESP: cyc/stb drop at the next edge, the response is discarded, state=IDLE.
- Timer width is clog2(TIMEOUT_CYCLES+1) and it saturates, never wrapping.
- No pipelined or burst cycles. cti/bte/err are not supported.

Optional Feature:
- Macro: WB_BRINGUP_INITIATOR_STATS_EN.
- When defined, adds output ports `stat_txn_count[15:0]` and `stat_timeout_count[15:0]`:
  - stat_txn_count increments on every BUS→RESP transition.
  - stat_timeout_count increments on each timeout.
  - Both are 0 on reset, saturate at 16'hFFFF, and are registered.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Write, slave acks 1 cycle after stb: cmd we=1 adr=32'h3000_0004 dat=32'hA5A5_1234 sel=4'hF → bus holds these values while stb=1; rsp_valid with rsp_dat=0, rsp_timeout=0; cyc low the cycle after ack.
- Read with 5 wait states, slave returns 32'hCAFE_F00D: cmd we=0 adr=32'h3000_0000 → stb held 6 cycles; rsp_dat=32'hCAFE_F00D; cmd_ready low from acceptance until rsp handshake.
- Timeout, TIMEOUT_CYCLES=8, no ack: read cmd → stb high exactly 8 cycles then drops; rsp_timeout=1, rsp_dat=0. With stats enabled, stat_timeout_count=1 and stat_txn_count=1.
- Response backpressure: rsp_ready held low 10 cycles after a read of 32'h0000_00FF → rsp_valid and rsp_dat stable for all 10 cycles; a cmd_valid offered during that time is not accepted.
- Reset during BUS: assert reset 2 cycles into stb → next edge cyc=stb=0 and rsp_valid=0; after release, a fresh write completes normally.
- Ack on timeout terminal cycle (TIMEOUT_CYCLES=4, ack on 4th stb cycle with 32'h1234_5678) → rsp_timeout=0, rsp_dat=32'h1234_5678.
